// File: rtl/array_sequencer_if.sv
// Handshake and row-control bundle for array_sequencer.
// ARRAY_SEQUENCER_PERF_CNT_EN adds the 32-bit perf_cycles signal.
interface array_sequencer_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned KW = $clog2(N + 1);

    logic          start;
    logic [KW-1:0] active_rows;
    logic          stall;
    logic [N-1:0]  load_weight;
    logic [N-1:0]  enable_mult;
    logic          busy;
    logic          done;

`ifdef ARRAY_SEQUENCER_PERF_CNT_EN
    logic [31:0]   perf_cycles;

    modport master (
        output start, active_rows, stall,
        input  load_weight, enable_mult, busy, done, perf_cycles
    );
    modport slave (
        input  start, active_rows, stall,
        output load_weight, enable_mult, busy, done, perf_cycles
    );
`else
    modport master (
        output start, active_rows, stall,
        input  load_weight, enable_mult, busy, done
    );
    modport slave (
        input  start, active_rows, stall,
        output load_weight, enable_mult, busy, done
    );
`endif
endinterface

// File: rtl/array_sequencer.sv
// Wavefront sequencer for an N-row array: loads one row weight per cycle, then
// streams a diagonal enable wavefront advancing one row every STEP cycles.
// ARRAY_SEQUENCER_PERF_CNT_EN adds a busy-cycle counter on bus.perf_cycles.
module array_sequencer #(
    parameter int unsigned N    = 4,
    parameter int unsigned STEP = 4
) (
    input logic              clk,
    input logic              reset,
    array_sequencer_if.slave bus
);
    localparam int unsigned KW = $clog2(N + 1);
    localparam int unsigned CW = $clog2(2 * N * STEP + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

    state_e        r_state, w_state_nxt;
    logic [KW-1:0] r_k, w_k_nxt, w_k_sel;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [CW-1:0] w_k_step, w_k_step_nxt, w_stream_last;
    logic          w_accept;
    logic [N-1:0]  r_load_weight, w_load_weight_nxt;
    logic [N-1:0]  r_enable_mult, w_enable_mult_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;

    assign w_accept      = (r_state == StIdle) && bus.start && !bus.stall;
    assign w_k_step      = CW'(r_k) * CW'(STEP);
    assign w_k_step_nxt  = CW'(w_k_nxt) * CW'(STEP);
    // Last stream count is (2K-1)*STEP - 1.
    assign w_stream_last = (w_k_step << 1) - CW'(STEP) - CW'(1);

    // Clamp the requested row count: zero or out-of-range selects the full array.
    always_comb begin
        w_k_sel = bus.active_rows;
        if (bus.active_rows == '0 || bus.active_rows > KW'(N)) begin
            w_k_sel = KW'(N);
        end
    end

    // Next-state and phase counter; a stall in LOAD/STREAM leaves everything as is.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = StLoad;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = w_k_sel;
                end
            end
            StLoad: begin
                if (!bus.stall) begin
                    if (r_cnt == CW'(r_k) - CW'(1)) begin
                        w_state_nxt = StStream;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            StStream: begin
                if (!bus.stall) begin
                    if (r_cnt == w_stream_last) begin
                        w_state_nxt = StDone;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so the
    // outputs can be registered; an unchanged state decodes to unchanged outputs.
    always_comb begin
        w_load_weight_nxt = '0;
        w_enable_mult_nxt = '0;
        w_busy_nxt        = 1'b0;
        w_done_nxt        = 1'b0;
        case (w_state_nxt)
            StLoad: begin
                w_busy_nxt = 1'b1;
                for (int unsigned j = 0; j < N; j++) begin
                    w_load_weight_nxt[j] = (w_cnt_nxt == CW'(j));
                end
            end
            StStream: begin
                w_busy_nxt = 1'b1;
                // Row j is live for K*STEP cycles starting at j*STEP.
                for (int unsigned j = 0; j < N; j++) begin
                    w_enable_mult_nxt[j] = (KW'(j) < w_k_nxt) &&
                                           (w_cnt_nxt >= CW'(j * STEP)) &&
                                           (w_cnt_nxt < CW'(j * STEP) + w_k_step_nxt);
                end
            end
            StDone: begin
                w_done_nxt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_k           <= KW'(N);
            r_load_weight <= '0;
            r_enable_mult <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_k           <= w_k_nxt;
            r_load_weight <= w_load_weight_nxt;
            r_enable_mult <= w_enable_mult_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
        end
    end

    assign bus.load_weight = r_load_weight;
    assign bus.enable_mult = r_enable_mult;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

`ifdef ARRAY_SEQUENCER_PERF_CNT_EN
    logic [31:0] r_perf_cycles;

    // Busy-cycle counter: cleared on acceptance, counts stalled cycles, holds after done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_cycles <= '0;
        end else if (w_accept) begin
            r_perf_cycles <= '0;
        end else if (r_busy) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign bus.perf_cycles = r_perf_cycles;
`else
    // No performance counter in this build.
`endif
endmodule
